// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter.
// The lock signal is present only when REG_ARB_LOCK_EN is defined.
interface reg_write_arbiter_if #(
   parameter int WIDTH = 7,
   parameter int NREQ  = 4,
   parameter int IW    = $clog2(NREQ)
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data_in;
`ifdef REG_ARB_LOCK_EN
   logic                  lock;
`endif
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      q;
   logic [IW-1:0]         owner;
   logic                  busy;

`ifdef REG_ARB_LOCK_EN
   modport master (output req, data_in, lock, input grant, ack, q, owner, busy);
   modport slave  (input req, data_in, lock, output grant, ack, q, owner, busy);
`else
   modport master (output req, data_in, input grant, ack, q, owner, busy);
   modport slave  (input req, data_in, output grant, ack, q, owner, busy);
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin req/grant/ack write arbiter owning one shared WIDTH-bit register.
// Optional macro REG_ARB_LOCK_EN adds a lock input that pins arbitration to one requester.
module reg_write_arbiter #(
   parameter int WIDTH = 7,
   parameter int NREQ  = 4
) (
   input logic                clk,
   input logic                reset,
   reg_write_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_GRANT  = 2'b01,
      S_COMMIT = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    r_owner;
   logic [WIDTH-1:0] r_q;
   logic [IW-1:0]    w_sel;
   logic [IW-1:0]    w_cand;
   logic             w_any;
   logic             w_req_idx;
   logic [NREQ-1:0]  w_req_eff;
   logic [NREQ-1:0]  w_idx_oh;
   logic [WIDTH-1:0] w_din_sel;

`ifdef REG_ARB_LOCK_EN
   logic             r_locked;
   logic [IW-1:0]    r_lock_idx;

   // While locked only the lock holder is visible to the IDLE search.
   assign w_req_eff = r_locked ? (bus.req & (NREQ'(1) << r_lock_idx)) : bus.req;
`else
   assign w_req_eff = bus.req;
`endif

   assign w_req_idx = bus.req[r_idx];
   assign w_idx_oh  = NREQ'(1) << r_idx;

   // Walk ptr+NREQ down to ptr+1 so the nearest requester after ptr is the final winner.
   always_comb begin
      w_sel  = r_ptr;
      w_any  = 1'b0;
      w_cand = '0;
      for (int k = NREQ; k >= 1; k--) begin
         w_cand = IW'((int'(r_ptr) + k) % NREQ);
         if (w_req_eff[w_cand]) begin
            w_sel = w_cand;
            w_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_din_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_idx == IW'(i)) w_din_sel = bus.data_in[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE:  w_state_nxt = w_any ? S_GRANT : S_IDLE;
         S_GRANT: w_state_nxt = w_req_idx ? S_COMMIT : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx      <= '0;
         r_ptr      <= IW'(NREQ - 1);
         r_owner    <= '0;
         r_q        <= '0;
`ifdef REG_ARB_LOCK_EN
         r_locked   <= 1'b0;
         r_lock_idx <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) r_idx <= w_sel;
            end
            S_GRANT: begin
               if (w_req_idx) begin
                  r_q     <= w_din_sel;
                  r_owner <= r_idx;
               end
`ifdef REG_ARB_LOCK_EN
               else if (r_locked && (r_idx == r_lock_idx)) r_locked <= 1'b0;
`endif
            end
            S_COMMIT: begin
               r_ptr <= r_idx;
`ifdef REG_ARB_LOCK_EN
               r_locked <= bus.lock;
               if (bus.lock) r_lock_idx <= r_idx;
`endif
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs come only from registered state so req never reaches them combinationally.
   assign bus.grant = (r_state == S_GRANT)  ? w_idx_oh : '0;
   assign bus.ack   = (r_state == S_COMMIT) ? w_idx_oh : '0;
   assign bus.busy  = (r_state != S_IDLE);
   assign bus.q     = r_q;
   assign bus.owner = r_owner;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; expected commits queue up as stimulus is issued
// and a negedge monitor checks each ack against them. Lock scenario runs with REG_ARB_LOCK_EN.
module tb_reg_write_arbiter;
   localparam int WIDTH = 7;
   localparam int NREQ  = 4;

   typedef struct {
      int         idx;
      logic [6:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   int         total = 0;
   int         bad   = 0;
   exp_t       sb[$];
   logic [6:0] tab  [NREQ][2];
   int         pend [NREQ];
   int         widx [NREQ];
   int         lk_cnt;
   logic       lock_drv;

   reg_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int i, input logic [6:0] d);
      exp_t e;
      e.idx = i;
      e.d   = d;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [6:0] d);
      bus.data_in[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic drive_lock(input int acks);
      lock_drv = (acks < lk_cnt);
`ifdef REG_ARB_LOCK_EN
      bus.lock = lock_drv;
`endif
   endtask

   // Each requester holds req until acked, drops it for one cycle, then re-raises while work remains.
   task automatic run_auto();
      logic [NREQ-1:0] a;
      int acks;
      int cyc;
      int left;
      acks = 0;
      cyc  = 0;
      left = 0;
      for (int i = 0; i < NREQ; i++) begin
         widx[i] = 0;
         left += pend[i];
         if (pend[i] > 0) set_data(i, tab[i][0]);
         bus.req[i] = (pend[i] > 0);
      end
      drive_lock(acks);
      while (((bus.req != '0) || (left > 0)) && (cyc < 60)) begin
         a = bus.ack;
         tick();
         cyc++;
         for (int i = 0; i < NREQ; i++) begin
            if (a[i]) begin
               pend[i]--;
               widx[i]++;
               acks++;
               left--;
               bus.req[i] = 1'b0;
            end else if ((pend[i] > 0) && !bus.req[i]) begin
               set_data(i, tab[i][widx[i]]);
               bus.req[i] = 1'b1;
            end
         end
         drive_lock(acks);
      end
      chk("auto_within_budget", 32'(cyc < 60), 32'd1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset && (bus.ack != '0)) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("ack", 32'(bus.ack), 32'd1 << e.idx);
               chk("q", 32'(bus.q), 32'(e.d));
               chk("owner", 32'(bus.owner), 32'(e.idx));
            end
         end
      end
   end

   initial begin
      reset       = 1'b1;
      bus.req     = '0;
      bus.data_in = '0;
      lk_cnt      = 0;
      lock_drv    = 1'b0;
`ifdef REG_ARB_LOCK_EN
      bus.lock    = 1'b0;
`endif
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      tick();
      tick();
      chk("rst_q", 32'(bus.q), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;
      tick();

      // single write from requester 2
      set_data(2, 7'h5A);
      bus.req = 4'b0100;
      push(2, 7'h5A);
      tick();
      chk("single_grant", 32'(bus.grant), 32'h4);
      chk("single_busy_g", 32'(bus.busy), 32'd1);
      chk("single_noack_g", 32'(bus.ack), 32'd0);
      tick();
      chk("single_busy_c", 32'(bus.busy), 32'd1);
      chk("single_grant_c", 32'(bus.grant), 32'd0);
      bus.req = '0;
      tick();
      chk("single_idle", 32'(bus.busy), 32'd0);
      chk("single_q_hold", 32'(bus.q), 32'h5A);

      // reset while requester 0 is granted
      set_data(0, 7'h33);
      bus.req = 4'b0001;
      tick();
      chk("rg_grant", 32'(bus.grant), 32'h1);
      reset = 1'b1;
      #1;
      chk("rg_q", 32'(bus.q), 32'd0);
      chk("rg_grant0", 32'(bus.grant), 32'd0);
      chk("rg_ack", 32'(bus.ack), 32'd0);
      chk("rg_busy", 32'(bus.busy), 32'd0);
      chk("rg_owner", 32'(bus.owner), 32'd0);
      bus.req = '0;
      tick();
      reset = 1'b0;
      tick();

      // fairness: all four request, requester 0 first after reset
      tab[0][0] = 7'h11; tab[0][1] = 7'h15;
      tab[1][0] = 7'h22; tab[2][0] = 7'h33; tab[3][0] = 7'h44;
      pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
      push(0, 7'h11); push(1, 7'h22); push(2, 7'h33); push(3, 7'h44); push(0, 7'h15);
      run_auto();
      chk("fair_q_final", 32'(bus.q), 32'h15);

      // abandon: requester 1 drops req while granted
      set_data(1, 7'h2B);
      bus.req = 4'b0010;
      tick();
      chk("ab_grant", 32'(bus.grant), 32'h2);
      bus.req = '0;
      tick();
      chk("ab_idle", 32'(bus.busy), 32'd0);
      chk("ab_q_kept", 32'(bus.q), 32'h15);
      chk("ab_owner_kept", 32'(bus.owner), 32'd0);

      // pointer still at 0, so requester 1 precedes requester 2
      tab[1][0] = 7'h2C; tab[2][0] = 7'h3D;
      pend[1] = 1; pend[2] = 1;
      push(1, 7'h2C); push(2, 7'h3D);
      run_auto();

      tab[0][0] = 7'h01;
      pend[0] = 1;
      push(0, 7'h01);
      run_auto();

      // ptr=0 with req=1001: requester 3 wins first
      tab[0][0] = 7'h7F; tab[3][0] = 7'h40;
      pend[0] = 1; pend[3] = 1;
      push(3, 7'h40); push(0, 7'h7F);
      run_auto();

`ifdef REG_ARB_LOCK_EN
      lk_cnt = 1;
      tab[1][0] = 7'h12;
      pend[1] = 1;
      push(1, 7'h12);
      run_auto();
      tab[0][0] = 7'h06; tab[1][0] = 7'h13; tab[1][1] = 7'h14; tab[3][0] = 7'h36;
      pend[0] = 1; pend[1] = 2; pend[3] = 1;
      push(1, 7'h13); push(1, 7'h14); push(3, 7'h36); push(0, 7'h06);
      run_auto();
      lk_cnt = 0;
      drive_lock(0);
`endif

      tick();
      tick();
      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
